// File: rtl/ccx_ic_sram.sv
// On-chip SRAM responder for the CCX arbiter rsp side: rdata/err registered one cycle after gnt.
// gnt follows req after WAIT cycles (req held until gnt); define CCX_IC_SRAM_PRV_CHECK_EN to fault user writes.
module ccx_ic_sram #(
   parameter int              AW    = 39,
   parameter int              DW    = 64,
   parameter logic [AW-1:0]   BASE  = '0,
   parameter int              WORDS = 1024,
   parameter int              WAIT  = 0
) (
   input  logic              g_clk,
   input  logic              g_resetn,
   input  logic              mem_req,
   output logic              mem_gnt,
   input  logic [1:0]        mem_rtype,
   input  logic [AW-1:0]     mem_addr,
   input  logic              mem_wen,
   input  logic [DW/8-1:0]   mem_strb,
   input  logic [DW-1:0]     mem_wdata,
   input  logic              mem_prv,
   output logic              mem_err,
   output logic [DW-1:0]     mem_rdata
);

   localparam int BW   = DW / 8;
   localparam int OFFW = $clog2(BW);
   localparam int IW   = (WORDS > 1) ? $clog2(WORDS) : 1;

   // One extra bit so BASE + array size cannot wrap around the address space.
   localparam logic [AW:0] BASE_X  = {1'b0, BASE};
   localparam logic [AW:0] LIMIT_X = BASE_X + (AW+1)'(WORDS * BW);
   localparam logic [3:0]  WAIT_C  = 4'(WAIT);

   typedef enum logic {
      S_IDLE,
      S_COUNT
   } state_t;

   state_t          state_q, state_d;
   logic [3:0]      cnt_q, cnt_d;

   logic [AW:0]     addr_x;
   logic [AW:0]     off_x;
   logic            hit;
   logic [IW-1:0]   idx;
   logic            prv_fault;
   logic            wr_fire;
   logic            unused_sink;

   logic [DW-1:0]   mem_arr [WORDS];

   assign addr_x = {1'b0, mem_addr};
   assign off_x  = addr_x - BASE_X;
   assign hit    = (addr_x >= BASE_X) && (addr_x < LIMIT_X);
   assign idx    = off_x[OFFW +: IW];

`ifdef CCX_IC_SRAM_PRV_CHECK_EN
   assign prv_fault   = mem_wen & ~mem_prv & hit;
   assign unused_sink = ^{mem_rtype, off_x};
`else
   assign prv_fault   = 1'b0;
   assign unused_sink = ^{mem_rtype, off_x, mem_prv};
`endif

   always_ff @(posedge g_clk) begin
      if (!g_resetn) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         S_IDLE: begin
            if (mem_req && (WAIT != 0)) begin
               state_d = S_COUNT;
               cnt_d   = 4'd1;
            end
         end
         S_COUNT: begin
            // A dropped req aborts the count just like a completed grant does.
            if (!mem_req || (cnt_q == WAIT_C)) begin
               state_d = S_IDLE;
               cnt_d   = '0;
            end else begin
               cnt_d   = cnt_q + 4'd1;
            end
         end
         default: begin
            state_d = S_IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   always_comb begin
      mem_gnt = 1'b0;
      if (g_resetn) begin
         if (WAIT == 0) begin
            mem_gnt = mem_req;
         end else if ((state_q == S_COUNT) && (cnt_q == WAIT_C)) begin
            mem_gnt = mem_req;
         end
      end
   end

   assign wr_fire = mem_gnt & mem_wen & hit & ~prv_fault;

   always_ff @(posedge g_clk) begin
      if (wr_fire) begin
         for (int i = 0; i < BW; i++) begin
            if (mem_strb[i]) begin
               mem_arr[idx][8*i +: 8] <= mem_wdata[8*i +: 8];
            end
         end
      end
   end

   // err pulses for the single response cycle; rdata holds until the next response.
   always_ff @(posedge g_clk) begin
      if (!g_resetn) begin
         mem_err   <= 1'b0;
         mem_rdata <= '0;
      end else if (mem_gnt) begin
         mem_err   <= ~hit | prv_fault;
         mem_rdata <= (!mem_wen && hit) ? mem_arr[idx] : '0;
      end else begin
         mem_err   <= 1'b0;
      end
   end

endmodule

// File: tb/tb_ccx_ic_sram.sv
// Bench for ccx_ic_sram: directed vector table, WAIT=3 timing sequences, and a randomized
// scoreboard run against a byte-level memory model.
module tb_ccx_ic_sram;

   localparam logic [38:0] BASE0 = 39'h1000;
   localparam longint unsigned SIZE0 = 1024 * 8;
`ifdef CCX_IC_SRAM_PRV_CHECK_EN
   localparam bit PRV_EN = 1'b1;
`else
   localparam bit PRV_EN = 1'b0;
`endif

   logic        clk;
   logic        rstn;

   logic        a_req, a_gnt, a_wen, a_prv, a_err;
   logic [1:0]  a_rtype;
   logic [38:0] a_addr;
   logic [7:0]  a_strb;
   logic [63:0] a_wdata, a_rdata;

   logic        b_req, b_gnt, b_wen, b_prv, b_err;
   logic [1:0]  b_rtype;
   logic [38:0] b_addr;
   logic [7:0]  b_strb;
   logic [63:0] b_wdata, b_rdata;

   int cmp_cnt = 0;
   int fail_cnt = 0;

   typedef struct {
      logic        err;
      logic [63:0] rdata;
   } rsp_t;

   typedef struct {
      logic        wen;
      logic [38:0] addr;
      logic [7:0]  strb;
      logic [63:0] wdata;
      logic        prv;
      logic        err;
      logic [63:0] rdata;
   } vec_t;

   rsp_t        expq[$];
   rsp_t        r_mon;
   logic [63:0] model [1024];
   logic        resp_due = 1'b0;
   logic [63:0] last_rdata = '0;
   vec_t        tbl [13];

   ccx_ic_sram #(.AW(39), .DW(64), .BASE(BASE0), .WORDS(1024), .WAIT(0)) u_dut0 (
      .g_clk(clk), .g_resetn(rstn),
      .mem_req(a_req), .mem_gnt(a_gnt), .mem_rtype(a_rtype), .mem_addr(a_addr),
      .mem_wen(a_wen), .mem_strb(a_strb), .mem_wdata(a_wdata), .mem_prv(a_prv),
      .mem_err(a_err), .mem_rdata(a_rdata)
   );

   ccx_ic_sram #(.AW(39), .DW(64), .BASE(39'h0), .WORDS(1024), .WAIT(3)) u_dut3 (
      .g_clk(clk), .g_resetn(rstn),
      .mem_req(b_req), .mem_gnt(b_gnt), .mem_rtype(b_rtype), .mem_addr(b_addr),
      .mem_wen(b_wen), .mem_strb(b_strb), .mem_wdata(b_wdata), .mem_prv(b_prv),
      .mem_err(b_err), .mem_rdata(b_rdata)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      cmp_cnt++;
      if (act !== exp) begin
         fail_cnt++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   // Reference behaviour: byte address range check, word index by division, byte-wise merge.
   task automatic model_grant();
      longint unsigned a;
      longint unsigned w;
      logic            hit;
      logic            fault;
      rsp_t            r;
      a     = longint'(a_addr);
      hit   = (a >= longint'(BASE0)) && (a < longint'(BASE0) + SIZE0);
      w     = hit ? (a - longint'(BASE0)) / 8 : 0;
      fault = PRV_EN && a_wen && !a_prv && hit;
      if (a_wen && hit && !fault) begin
         for (int b = 0; b < 8; b++) begin
            if (a_strb[b]) model[w][8*b +: 8] = a_wdata[8*b +: 8];
         end
      end
      r.err   = !hit || fault;
      r.rdata = (!a_wen && hit) ? model[w] : 64'h0;
      expq.push_back(r);
   endtask

   always @(negedge clk) begin
      if (!rstn) begin
         chk("rst_gnt0", 64'(a_gnt), 64'd0);
         chk("rst_err0", 64'(a_err), 64'd0);
         chk("rst_rdata0", a_rdata, 64'd0);
         chk("rst_gnt3", 64'(b_gnt), 64'd0);
         chk("rst_err3", 64'(b_err), 64'd0);
         resp_due   = 1'b0;
         last_rdata = '0;
      end else begin
         if (resp_due) begin
            chk("sb_nonempty", 64'(expq.size() != 0), 64'd1);
            if (expq.size() != 0) begin
               r_mon = expq.pop_front();
               chk("rsp_err", 64'(a_err), 64'(r_mon.err));
               chk("rsp_rdata", a_rdata, r_mon.rdata);
               last_rdata = r_mon.rdata;
            end
         end else begin
            chk("idle_err", 64'(a_err), 64'd0);
            chk("idle_rdata_hold", a_rdata, last_rdata);
         end
         resp_due = a_gnt;
         if (a_gnt) model_grant();
      end
   end

   // Entered and left at 1 time unit after a posedge.
   task automatic txn0(input logic wen, input logic [38:0] addr, input logic [7:0] strb,
                       input logic [63:0] wdata, input logic prv,
                       output logic rerr, output logic [63:0] rdat);
      int lat;
      bit got;
      a_wen = wen; a_addr = addr; a_strb = strb; a_wdata = wdata; a_prv = prv;
      a_rtype = 2'($urandom); a_req = 1'b1;
      got = 1'b0; lat = 0;
      for (int w = 0; w < 16 && !got; w++) begin
         @(negedge clk);
         if (a_gnt) begin
            got = 1'b1; lat = w;
         end else begin
            @(posedge clk); #1;
         end
      end
      chk("gnt_latency", got ? 64'(lat) : 64'hFFFF, 64'd0);
      @(posedge clk); #1;
      a_req = 1'b0;
      @(negedge clk);
      rerr = a_err;
      rdat = a_rdata;
      @(posedge clk); #1;
   endtask

   function automatic logic [38:0] rnd_addr();
      int r;
      r = $urandom_range(0, 9);
      if (r < 8) return BASE0 + 39'($urandom_range(0, 15) * 8 + $urandom_range(0, 7));
      else if (r == 8) return BASE0 + 39'(SIZE0) + 39'($urandom_range(0, 255) * 8);
      else return 39'($urandom_range(0, 32'hFFF));
   endfunction

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not complete in time");
      $fatal(1, "watchdog");
   end

   initial begin
      logic        e;
      logic [63:0] d;
      bit [11:0]   rq, eg, ee;

      tbl[0]  = '{1'b1, 39'h1008, 8'hFF, 64'h1122334455667788, 1'b1, 1'b0, 64'h0};
      tbl[1]  = '{1'b0, 39'h1008, 8'h00, 64'h0, 1'b1, 1'b0, 64'h1122334455667788};
      tbl[2]  = '{1'b1, 39'h1008, 8'h0F, 64'hAAAAAAAA_BBBBBBBB, 1'b1, 1'b0, 64'h0};
      tbl[3]  = '{1'b0, 39'h100F, 8'h00, 64'h0, 1'b1, 1'b0, 64'h11223344_BBBBBBBB};
      tbl[4]  = '{1'b0, 39'h3000, 8'h00, 64'h0, 1'b1, 1'b1, 64'h0};
      tbl[5]  = '{1'b0, 39'h0FF8, 8'h00, 64'h0, 1'b1, 1'b1, 64'h0};
      tbl[6]  = '{1'b1, 39'h3000, 8'hFF, 64'h5555, 1'b1, 1'b1, 64'h0};
      tbl[7]  = '{1'b1, 39'h2FF8, 8'hFF, 64'hCAFEF00D_01234567, 1'b1, 1'b0, 64'h0};
      tbl[8]  = '{1'b0, 39'h2FF8, 8'h00, 64'h0, 1'b0, 1'b0, 64'hCAFEF00D_01234567};
      tbl[9]  = '{1'b1, 39'h1000, 8'hFF, 64'h0BAD0BAD_0BAD0BAD, 1'b1, 1'b0, 64'h0};
      tbl[10] = '{1'b1, 39'h1000, 8'hFF, 64'hDEAD, 1'b0, PRV_EN, 64'h0};
      tbl[11] = '{1'b0, 39'h1000, 8'h00, 64'h0, 1'b1, 1'b0,
                  PRV_EN ? 64'h0BAD0BAD_0BAD0BAD : 64'hDEAD};
      tbl[12] = '{1'b0, 39'h7F_FFFF_FFF8, 8'h00, 64'h0, 1'b1, 1'b1, 64'h0};

      // Reset held three cycles with requests pending on both instances.
      rstn = 1'b0;
      a_req = 1'b1; a_wen = 1'b1; a_addr = 39'h0; a_strb = 8'hFF; a_wdata = '0;
      a_prv = 1'b1; a_rtype = 2'b00;
      b_req = 1'b1; b_wen = 1'b0; b_addr = 39'h2000; b_strb = 8'h00; b_wdata = '0;
      b_prv = 1'b1; b_rtype = 2'b00;
      repeat (3) @(posedge clk);
      #1;
      rstn  = 1'b1;
      b_req = 1'b0;
      @(negedge clk);
      chk("first_gnt_after_reset", 64'(a_gnt), 64'd1);
      @(posedge clk); #1;
      a_req = 1'b0;
      @(posedge clk); #1;

      for (int i = 0; i < 13; i++) begin
         txn0(tbl[i].wen, tbl[i].addr, tbl[i].strb, tbl[i].wdata, tbl[i].prv, e, d);
         chk($sformatf("tbl%0d_err", i), 64'(e), 64'(tbl[i].err));
         chk($sformatf("tbl%0d_rdata", i), d, tbl[i].rdata);
      end

      // Write then read of the same word on consecutive grant cycles.
      a_wen = 1'b1; a_addr = 39'h1010; a_strb = 8'hFF; a_wdata = 64'h1122334455667788;
      a_prv = 1'b1; a_req = 1'b1;
      @(negedge clk);
      chk("b2b_wr_gnt", 64'(a_gnt), 64'd1);
      @(posedge clk); #1;
      a_wen = 1'b0;
      @(negedge clk);
      chk("b2b_rd_gnt", 64'(a_gnt), 64'd1);
      chk("b2b_wr_err", 64'(a_err), 64'd0);
      @(posedge clk); #1;
      a_req = 1'b0;
      @(negedge clk);
      chk("b2b_raw_rdata", a_rdata, 64'h1122334455667788);
      chk("b2b_raw_err", 64'(a_err), 64'd0);
      @(posedge clk); #1;

      // WAIT=3: held req grants in cycle 3, a new req in cycle 4 grants in cycle 7.
      rq = 12'h0FF; eg = 12'h088; ee = 12'h110;
      for (int c = 0; c < 12; c++) begin
         b_req = rq[c];
         @(negedge clk);
         chk($sformatf("w3_gnt_c%0d", c), 64'(b_gnt), 64'(eg[c]));
         chk($sformatf("w3_err_c%0d", c), 64'(b_err), 64'(ee[c]));
         chk($sformatf("w3_rdata_c%0d", c), b_rdata, 64'd0);
         @(posedge clk); #1;
      end
      // req dropped mid-count restarts the wait from scratch.
      rq = 12'h07B; eg = 12'h040; ee = 12'h080;
      for (int c = 0; c < 12; c++) begin
         b_req = rq[c];
         @(negedge clk);
         chk($sformatf("w3_abort_gnt_c%0d", c), 64'(b_gnt), 64'(eg[c]));
         chk($sformatf("w3_abort_err_c%0d", c), 64'(b_err), 64'(ee[c]));
         @(posedge clk); #1;
      end

      for (int i = 0; i < 16; i++) begin
         txn0(1'b1, BASE0 + 39'(i * 8), 8'hFF, {$urandom, $urandom}, 1'b1, e, d);
      end

      for (int n = 0; n < 150; n++) begin
         if ($urandom_range(0, 3) == 0) begin
            int len;
            len = $urandom_range(2, 6);
            for (int k = 0; k < len; k++) begin
               a_wen = 1'($urandom_range(0, 1)); a_addr = rnd_addr(); a_strb = 8'($urandom);
               a_wdata = {$urandom, $urandom}; a_prv = 1'($urandom_range(0, 1));
               a_rtype = 2'($urandom); a_req = 1'b1;
               @(negedge clk);
               chk("burst_gnt", 64'(a_gnt), 64'd1);
               @(posedge clk); #1;
            end
            a_req = 1'b0;
            @(posedge clk); #1;
         end else begin
            txn0(1'($urandom_range(0, 1)), rnd_addr(), 8'($urandom), {$urandom, $urandom},
                 1'($urandom_range(0, 1)), e, d);
            repeat ($urandom_range(0, 2)) begin
               @(posedge clk); #1;
            end
         end
      end

      repeat (3) @(posedge clk);
      #1;
      chk("sb_drain", 64'(expq.size()), 64'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", cmp_cnt, fail_cnt);
      $finish;
   end

endmodule
